// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter: FSM states, port ids
// and the controller access-width codes.
package mem_req_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // Controller access-width codes, shared with the DDR2 controller.
    localparam logic [1:0] RAM_WIDTH8  = 2'd0;
    localparam logic [1:0] RAM_WIDTH16 = 2'd1;
    localparam logic [1:0] RAM_WIDTH32 = 2'd2;
    localparam logic [1:0] RAM_WIDTH64 = 2'd3;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundles the fetch port, load/store port and controller strobe/complete port.
// slave = arbiter view, master = CPU/controller environment view.
interface mem_req_arbiter_if #(
    parameter int unsigned ADDR_W = 28
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic              i_rsp_valid;
    logic [31:0]       i_rsp_data;
    logic              i_rsp_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [1:0]        d_width;
    logic              d_signed;
    logic [63:0]       d_wdata;
    logic              d_ack;
    logic              d_rsp_valid;
    logic [63:0]       d_rsp_data;
    logic              d_rsp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] mem_read_addr;
    logic [1:0]        mem_width;
    logic [63:0]       mem_data_in;
    logic [63:0]       mem_data_out;
    logic              mem_rstrobe;
    logic              mem_wstrobe;
    logic              mem_complete;
    logic              mem_ready;

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_rsp_valid, i_rsp_data, i_rsp_err,
        input  d_req, d_we, d_addr, d_width, d_signed, d_wdata,
        output d_ack, d_rsp_valid, d_rsp_data, d_rsp_err,
        output mem_addr, mem_read_addr, mem_width, mem_data_in,
        output mem_rstrobe, mem_wstrobe,
        input  mem_data_out, mem_complete, mem_ready
    );

    modport master (
        output i_req, i_addr,
        input  i_ack, i_rsp_valid, i_rsp_data, i_rsp_err,
        output d_req, d_we, d_addr, d_width, d_signed, d_wdata,
        input  d_ack, d_rsp_valid, d_rsp_data, d_rsp_err,
        input  mem_addr, mem_read_addr, mem_width, mem_data_in,
        input  mem_rstrobe, mem_wstrobe,
        output mem_data_out, mem_complete, mem_ready
    );

endinterface

// File: rtl/mem_rsp_align.sv
// Right-justifies MSB-aligned controller read data for the given access width
// and zero- or sign-extends it to 64 bits.
module mem_rsp_align
    import mem_req_arbiter_pkg::*;
(
    input  logic [63:0] raw,
    input  logic [1:0]  width,
    input  logic        sign_ext,
    output logic [63:0] data
);

    always_comb begin
        data = '0;
        case (width)
            RAM_WIDTH8:  data = {{56{sign_ext & raw[63]}}, raw[63:56]};
            RAM_WIDTH16: data = {{48{sign_ext & raw[63]}}, raw[63:48]};
            RAM_WIDTH32: data = {{32{sign_ext & raw[63]}}, raw[63:32]};
            default:     data = raw;
        endcase
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter of the fetch and load/store ports onto the single DDR2
// controller strobe/complete port, with completion timeout and drain.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned ADDR_W         = 28
) (
    input  logic cpu_clk,
    input  logic rst_p,
    mem_req_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    port_t             rr_last;
    port_t             cur_port;
    logic              cur_we;
    logic              cur_signed;
    logic [CNT_W-1:0]  cnt;

    logic              grant_i;
    logic              grant_d;
    logic [ADDR_W-1:0] grant_addr;
    logic [63:0]       aligned;

    // On contention the port not granted last wins; a lone requester always wins.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == ST_IDLE && bus.mem_ready) begin
            if (bus.i_req && bus.d_req) begin
                grant_d = (rr_last == PORT_I);
                grant_i = !grant_d;
            end else begin
                grant_i = bus.i_req;
                grant_d = bus.d_req;
            end
        end
        grant_addr = grant_d ? bus.d_addr : bus.i_addr;
    end

    mem_rsp_align u_align (
        .raw      (bus.mem_data_out),
        .width    (bus.mem_width),
        .sign_ext (cur_signed),
        .data     (aligned)
    );

    always_ff @(posedge cpu_clk) begin
        if (rst_p) begin
            state             <= ST_IDLE;
            rr_last           <= PORT_I;
            cur_port          <= PORT_I;
            cur_we            <= 1'b0;
            cur_signed        <= 1'b0;
            cnt               <= '0;
            bus.i_ack         <= 1'b0;
            bus.i_rsp_valid   <= 1'b0;
            bus.i_rsp_data    <= '0;
            bus.i_rsp_err     <= 1'b0;
            bus.d_ack         <= 1'b0;
            bus.d_rsp_valid   <= 1'b0;
            bus.d_rsp_data    <= '0;
            bus.d_rsp_err     <= 1'b0;
            bus.mem_addr      <= '0;
            bus.mem_read_addr <= '0;
            bus.mem_width     <= '0;
            bus.mem_data_in   <= '0;
            bus.mem_rstrobe   <= 1'b0;
            bus.mem_wstrobe   <= 1'b0;
        end else begin
            bus.i_ack       <= 1'b0;
            bus.d_ack       <= 1'b0;
            bus.mem_rstrobe <= 1'b0;
            bus.mem_wstrobe <= 1'b0;
            bus.i_rsp_valid <= 1'b0;
            bus.i_rsp_err   <= 1'b0;
            bus.i_rsp_data  <= '0;
            bus.d_rsp_valid <= 1'b0;
            bus.d_rsp_err   <= 1'b0;
            bus.d_rsp_data  <= '0;

            case (state)
                ST_IDLE: begin
                    if (grant_i || grant_d) begin
                        // Request fields stay latched until the next grant.
                        bus.mem_addr      <= grant_addr;
                        bus.mem_read_addr <= grant_addr;
                        state             <= ST_ISSUE;
                    end
                    if (grant_i) begin
                        bus.mem_width   <= RAM_WIDTH32;
                        bus.mem_data_in <= '0;
                        cur_we          <= 1'b0;
                        cur_signed      <= 1'b0;
                        cur_port        <= PORT_I;
                        rr_last         <= PORT_I;
                        bus.i_ack       <= 1'b1;
                    end else if (grant_d) begin
                        bus.mem_width   <= bus.d_width;
                        bus.mem_data_in <= bus.d_wdata;
                        cur_we          <= bus.d_we;
                        cur_signed      <= bus.d_signed;
                        cur_port        <= PORT_D;
                        rr_last         <= PORT_D;
                        bus.d_ack       <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    bus.mem_rstrobe <= !cur_we;
                    bus.mem_wstrobe <= cur_we;
                    cnt             <= '0;
                    state           <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (bus.mem_complete) begin
                        if (cur_port == PORT_I) begin
                            bus.i_rsp_valid <= 1'b1;
                            bus.i_rsp_data  <= aligned[31:0];
                        end else begin
                            bus.d_rsp_valid <= 1'b1;
                            bus.d_rsp_data  <= cur_we ? 64'd0 : aligned;
                        end
                        state <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        if (cur_port == PORT_I) begin
                            bus.i_rsp_valid <= 1'b1;
                            bus.i_rsp_err   <= 1'b1;
                        end else begin
                            bus.d_rsp_valid <= 1'b1;
                            bus.d_rsp_err   <= 1'b1;
                        end
                        state <= ST_DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RESP: state <= ST_IDLE;

                // The controller still owes a completion; swallow it before re-arbitrating.
                ST_DRAIN: begin
                    if (bus.mem_complete) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
